// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm clock's time/alarm setting front end.
package alarm_pkg;

  typedef enum logic [1:0] {IDLE, EDIT_HR, EDIT_MIN, LOAD} set_state_t;
  typedef enum logic {T_TIME, T_ALARM} set_tgt_t;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; one pulse per press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic sync1, sync2, prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven editor that seeds from the current time, edits hours then minutes,
// and presents BCD digits with a held LD_time/LD_alarm strobe to the clock core.
module time_set_ctrl
  import alarm_pkg::*;
#(
  parameter int LD_HOLD_CYC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_time,
  input  logic       btn_alarm,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       btn_cancel,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       busy,
  output logic       edit_min
);

  localparam int            CW       = $clog2(LD_HOLD_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LD_HOLD_CYC - 1);

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  // Out-of-range seeds (e.g. while the core shows garbage) start the edit at zero.
  function automatic logic [4:0] seed_hr(input logic [1:0] t, input logic [3:0] u);
    logic [7:0] s;
    s = 8'(t) * 8'd10 + 8'(u);
    return (s > 8'(HR_MAX)) ? 5'd0 : 5'(s);
  endfunction

  function automatic logic [5:0] seed_min(input logic [3:0] t, input logic [3:0] u);
    logic [7:0] s;
    s = 8'(t) * 8'd10 + 8'(u);
    return (s > 8'(MIN_MAX)) ? 6'd0 : 6'(s);
  endfunction

  logic p_time, p_alarm, p_up, p_down, p_ok, p_cancel;

  btn_edge u_time   (.clk(clk), .rst(rst), .in(btn_time),   .pulse(p_time));
  btn_edge u_alarm  (.clk(clk), .rst(rst), .in(btn_alarm),  .pulse(p_alarm));
  btn_edge u_up     (.clk(clk), .rst(rst), .in(btn_up),     .pulse(p_up));
  btn_edge u_down   (.clk(clk), .rst(rst), .in(btn_down),   .pulse(p_down));
  btn_edge u_ok     (.clk(clk), .rst(rst), .in(btn_ok),     .pulse(p_ok));
  btn_edge u_cancel (.clk(clk), .rst(rst), .in(btn_cancel), .pulse(p_cancel));

  set_state_t    state, state_n;
  set_tgt_t      tgt, tgt_n;
  logic [4:0]    hr_v, hr_n;
  logic [5:0]    min_v, min_n;
  logic [CW-1:0] cnt, cnt_n;

  logic inc, dec;
  assign inc = p_up & ~p_down;
  assign dec = p_down & ~p_up;

  // NOTE: every signal written here is defaulted first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    hr_n    = hr_v;
    min_n   = min_v;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (p_time || p_alarm) begin
          tgt_n   = p_time ? T_TIME : T_ALARM;
          hr_n    = seed_hr(cur_h1, cur_h0);
          min_n   = seed_min(cur_m1, cur_m0);
          state_n = EDIT_HR;
        end
      end
      EDIT_HR: begin
        if (p_cancel)  state_n = IDLE;
        else if (p_ok) state_n = EDIT_MIN;
        else if (inc)  hr_n = (hr_v == HR_MAX) ? 5'd0 : hr_v + 5'd1;
        else if (dec)  hr_n = (hr_v == 5'd0) ? HR_MAX : hr_v - 5'd1;
      end
      EDIT_MIN: begin
        if (p_cancel) state_n = IDLE;
        else if (p_ok) begin
          state_n = LOAD;
          cnt_n   = '0;
        end
        else if (inc) min_n = (min_v == MIN_MAX) ? 6'd0 : min_v + 6'd1;
        else if (dec) min_n = (min_v == 6'd0) ? MIN_MAX : min_v - 6'd1;
      end
      LOAD: begin
        if (cnt == CNT_LAST) state_n = IDLE;
        else                 cnt_n   = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobes decode the next state so they rise on LOAD entry and span exactly LD_HOLD_CYC cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tgt      <= T_TIME;
      hr_v     <= '0;
      min_v    <= '0;
      cnt      <= '0;
      LD_time  <= 1'b0;
      LD_alarm <= 1'b0;
      H_in1    <= '0;
      H_in0    <= '0;
      M_in1    <= '0;
      M_in0    <= '0;
    end else begin
      state    <= state_n;
      tgt      <= tgt_n;
      hr_v     <= hr_n;
      min_v    <= min_n;
      cnt      <= cnt_n;
      LD_time  <= (state_n == LOAD) && (tgt_n == T_TIME);
      LD_alarm <= (state_n == LOAD) && (tgt_n == T_ALARM);
      H_in1    <= 2'(tens_of({1'b0, hr_v}));
      H_in0    <= units_of({1'b0, hr_v});
      M_in1    <= tens_of(min_v);
      M_in0    <= units_of(min_v);
    end
  end

  assign busy     = (state != IDLE);
  assign edit_min = (state == EDIT_MIN);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: seed table, directed corner cases, random presses vs a model.
module tb_time_set_ctrl;

  localparam int HOLD = 10;

  localparam logic [5:0] B_TIME   = 6'b000001;
  localparam logic [5:0] B_ALARM  = 6'b000010;
  localparam logic [5:0] B_UP     = 6'b000100;
  localparam logic [5:0] B_DOWN   = 6'b001000;
  localparam logic [5:0] B_OK     = 6'b010000;
  localparam logic [5:0] B_CANCEL = 6'b100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_time = 0, btn_alarm = 0, btn_up = 0, btn_down = 0, btn_ok = 0, btn_cancel = 0;
  logic [1:0] cur_h1 = '0;
  logic [3:0] cur_h0 = '0, cur_m1 = '0, cur_m0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, busy, edit_min;

  time_set_ctrl #(.LD_HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst(rst),
    .btn_time(btn_time), .btn_alarm(btn_alarm), .btn_up(btn_up), .btn_down(btn_down),
    .btn_ok(btn_ok), .btn_cancel(btn_cancel),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .busy(busy), .edit_min(edit_min)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_dig;
  assign dut_dig = {2'b00, H_in1, H_in0, M_in1, M_in0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Strobe monitor: counts high cycles and flags digit changes or overlap while loading.
  int          n_ldt = 0, n_lda = 0, n_bad = 0;
  logic [15:0] exp_dig = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (LD_time)  n_ldt++;
      if (LD_alarm) n_lda++;
      if ((LD_time || LD_alarm) && (dut_dig !== exp_dig)) n_bad++;
      if (LD_time && LD_alarm) n_bad++;
    end
  end

  // Behavioural model at the level of whole button presses.
  typedef enum {P_IDLE, P_HOURS, P_MINUTES, P_LOADING} phase_t;
  phase_t m_phase = P_IDLE;
  bit     m_alarm = 0;
  int     m_hr = 0, m_min = 0;

  function automatic logic [15:0] model_dig();
    return {4'(m_hr / 10), 4'(m_hr % 10), 4'(m_min / 10), 4'(m_min % 10)};
  endfunction

  task automatic model_update(input logic [5:0] m);
    int h, mi;
    case (m_phase)
      P_IDLE: if (m[0] || m[1]) begin
        m_alarm = !m[0];
        h  = int'(cur_h1) * 10 + int'(cur_h0);
        mi = int'(cur_m1) * 10 + int'(cur_m0);
        m_hr    = (h > 23) ? 0 : h;
        m_min   = (mi > 59) ? 0 : mi;
        m_phase = P_HOURS;
      end
      P_HOURS: begin
        if (m[5])                m_phase = P_IDLE;
        else if (m[4])           m_phase = P_MINUTES;
        else if (m[2] && !m[3])  m_hr = (m_hr + 1) % 24;
        else if (m[3] && !m[2])  m_hr = (m_hr + 23) % 24;
      end
      P_MINUTES: begin
        if (m[5])                m_phase = P_IDLE;
        else if (m[4])           m_phase = P_LOADING;
        else if (m[2] && !m[3])  m_min = (m_min + 1) % 60;
        else if (m[3] && !m[2])  m_min = (m_min + 59) % 60;
      end
      default: ;
    endcase
  endtask

  task automatic set_btns(input logic [5:0] m);
    {btn_cancel, btn_ok, btn_down, btn_up, btn_alarm, btn_time} = m;
  endtask

  // Raise buttons at a falling edge, hold, release, then let pulses and outputs settle.
  task automatic press(input logic [5:0] m, input int hold);
    @(negedge clk);
    set_btns(m);
    repeat (hold) @(negedge clk);
    set_btns('0);
    repeat (4) @(negedge clk);
  endtask

  task automatic finish_load(input string name, input int t0, input int a0, input int b0);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check({name, "_load_timeout"}, 32'(busy), 32'd0);
    check({name, "_ld_time_cycles"}, n_ldt - t0, m_alarm ? 0 : HOLD);
    check({name, "_ld_alarm_cycles"}, n_lda - a0, m_alarm ? HOLD : 0);
    check({name, "_load_stable"}, n_bad - b0, 0);
    m_phase = P_IDLE;
  endtask

  task automatic do_press(input string name, input logic [5:0] m, input int hold = 2);
    int t0, a0, b0;
    t0 = n_ldt; a0 = n_lda; b0 = n_bad;
    exp_dig = model_dig();
    press(m, hold);
    model_update(m);
    check({name, "_digits"}, 32'(dut_dig), 32'(model_dig()));
    check({name, "_status"}, {busy, edit_min}, {m_phase != P_IDLE, m_phase == P_MINUTES});
    if (m_phase == P_LOADING) finish_load(name, t0, a0, b0);
    else check({name, "_no_ld"}, (n_ldt - t0) + (n_lda - a0), 0);
  endtask

  task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0);
    cur_h1 = h1; cur_h0 = h0; cur_m1 = m1; cur_m0 = m0;
  endtask

  typedef struct {
    logic [1:0]  h1;
    logic [3:0]  h0, m1, m0;
    logic [15:0] exp;
  } seed_vec_t;

  seed_vec_t vecs[7];

  initial begin
    int t0, a0, sum_busy;
    logic [5:0] m;

    vecs[0] = '{2'd1, 4'd1, 4'd2, 4'd6, 16'h1126};
    vecs[1] = '{2'd2, 4'd3, 4'd5, 4'd9, 16'h2359};
    vecs[2] = '{2'd2, 4'd7, 4'd6, 4'd1, 16'h0000};
    vecs[3] = '{2'd2, 4'd4, 4'd5, 4'd9, 16'h0059};
    vecs[4] = '{2'd0, 4'd9, 4'd15, 4'd0, 16'h0900};
    vecs[5] = '{2'd1, 4'd15, 4'd3, 4'd0, 16'h0030};
    vecs[6] = '{2'd0, 4'd7, 4'd0, 4'd7, 16'h0707};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {dut_dig, busy, edit_min, LD_time, LD_alarm}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_release_idle", {busy, edit_min, LD_time, LD_alarm}, 32'd0);

    // Seed table: enter, check seeded digits, cancel, check digits held
    foreach (vecs[i]) begin
      set_cur(vecs[i].h1, vecs[i].h0, vecs[i].m1, vecs[i].m0);
      do_press("seed_enter", B_TIME);
      check($sformatf("seed_tbl_%0d", i), 32'(dut_dig), 32'(vecs[i].exp));
      do_press("seed_cancel", B_CANCEL);
      check($sformatf("seed_held_%0d", i), 32'(dut_dig), 32'(vecs[i].exp));
    end

    // Time edit: 11:26 -> 14:24
    set_cur(2'd1, 4'd1, 4'd2, 4'd6);
    do_press("tedit_start", B_TIME);
    repeat (3) do_press("tedit_up", B_UP);
    do_press("tedit_ok_hr", B_OK);
    repeat (2) do_press("tedit_down", B_DOWN);
    do_press("tedit_ok_min", B_OK);
    check("tedit_final", 32'(dut_dig), 32'h1424);

    // Wraps from 23:59
    set_cur(2'd2, 4'd3, 4'd5, 4'd9);
    do_press("wrap_start", B_TIME);
    do_press("wrap_hr_up", B_UP);
    check("wrap_hr_up_val", 32'(dut_dig), 32'h0059);
    do_press("wrap_hr_down", B_DOWN);
    check("wrap_hr_down_val", 32'(dut_dig), 32'h2359);
    do_press("wrap_ok", B_OK);
    do_press("wrap_min_up", B_UP);
    check("wrap_min_up_val", 32'(dut_dig), 32'h2300);
    do_press("wrap_min_down", B_DOWN);
    check("wrap_min_down_val", 32'(dut_dig), 32'h2359);

    // Conflicts: up+down, held up, cancel+ok in minutes
    do_press("conf_updown", B_UP | B_DOWN);
    check("conf_updown_val", 32'(dut_dig), 32'h2359);
    do_press("conf_held_up", B_UP, 20);
    check("conf_held_up_val", 32'(dut_dig), 32'h2300);
    do_press("conf_cancel_ok", B_CANCEL | B_OK);
    check("conf_cancel_ok_idle", 32'(busy), 32'd0);

    // Alarm path: 06:00 -> 06:30
    set_cur(2'd0, 4'd6, 4'd0, 4'd0);
    do_press("alarm_start", B_ALARM);
    do_press("alarm_ok_hr", B_OK);
    repeat (30) do_press("alarm_up", B_UP);
    do_press("alarm_ok_min", B_OK);
    check("alarm_final", 32'(dut_dig), 32'h0630);

    // Time beats alarm when pressed together; held up in hours adds one
    set_cur(2'd0, 4'd8, 4'd1, 4'd5);
    do_press("both_start", B_TIME | B_ALARM);
    do_press("hr_held_up", B_UP, 15);
    check("hr_held_up_val", 32'(dut_dig), 32'h0915);
    do_press("both_ok_hr", B_OK);

    // Presses during LOAD are ignored
    t0 = n_ldt; a0 = n_lda;
    exp_dig = model_dig();
    begin
      int b0;
      b0 = n_bad;
      press(B_OK, 2);
      model_update(B_OK);
      press(B_UP | B_CANCEL | B_ALARM, 2);
      finish_load("load_ignore", t0, a0, b0);
    end
    check("load_ignore_digits", 32'(dut_dig), 32'h0915);

    // Reset during LOAD
    set_cur(2'd1, 4'd2, 4'd0, 4'd0);
    do_press("rload_start", B_TIME);
    do_press("rload_ok_hr", B_OK);
    @(negedge clk);
    set_btns(B_OK);
    repeat (2) @(negedge clk);
    set_btns('0);
    for (int i = 0; i < 10 && !LD_time; i++) @(negedge clk);
    check("rload_ld_seen", 32'(LD_time), 32'd1);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rload_ld_drop", {LD_time, LD_alarm, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_phase = P_IDLE; m_hr = 0; m_min = 0;
    repeat (2) @(negedge clk);
    check("rload_idle", {busy, edit_min, LD_time}, 32'd0);
    check("rload_digits", 32'(dut_dig), 32'd0);

    // Reset mid-edit, then quiet for 20 cycles
    set_cur(2'd1, 4'd7, 4'd4, 4'd2);
    do_press("rmid_start", B_TIME);
    do_press("rmid_ok", B_OK);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rmid_outputs", {dut_dig, busy, edit_min, LD_time, LD_alarm}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_phase = P_IDLE; m_hr = 0; m_min = 0;
    t0 = n_ldt; a0 = n_lda; sum_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) sum_busy++;
    end
    check("rmid_quiet_ld", (n_ldt - t0) + (n_lda - a0), 0);
    check("rmid_quiet_busy", sum_busy, 0);

    // Random presses against the model
    for (int k = 0; k < 150; k++) begin
      set_cur(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 9))
          0:       m = B_TIME;
          1:       m = B_ALARM;
          2, 3, 4: m = B_UP;
          5, 6, 7: m = B_DOWN;
          8:       m = B_OK;
          default: m = B_CANCEL;
        endcase
      end else begin
        m = 6'($urandom_range(1, 63));
      end
      do_press("rand", m, int'($urandom_range(1, 4)));
    end
    if (m_phase != P_IDLE) do_press("rand_end", B_CANCEL);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
